// File: rtl/hazard_unit.sv
// Pipeline hazard unit: in-flight destination scoreboard, operand forwarding selects,
// load-use stall and taken-branch flush. Define HAZARD_STATS_EN to enable the event counters.
module hazard_unit #(
   parameter  int DEPTH      = 2,
   parameter  int RA_W       = 5,
   parameter  int LOAD_READY = 2,
   localparam int SEL_W      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hold,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [RA_W-1:0]  id_rd,
   input  logic             id_we,
   input  logic             id_is_load,
   input  logic             ex_branch_taken,
   output logic             stall,
   output logic             flush,
   output logic [SEL_W-1:0] fwd_rs1_sel,
   output logic [SEL_W-1:0] fwd_rs2_sel,
   output logic [31:0]      stall_count,
   output logic [31:0]      flush_count
);

   // With a single tracked stage the producer is already at the write stage.
   localparam int LR_EFF = (DEPTH == 1) ? 1 : LOAD_READY;

   typedef struct packed {
      logic            valid;
      logic            we;
      logic            is_load;
      logic [RA_W-1:0] rd;
   } stage_t;

   stage_t stage_reg  [1:DEPTH];
   stage_t stage_next [1:DEPTH];
   logic   issue;

   assign issue = id_valid & ~stall & ~flush;

   generate
      for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_stage
         if (gi == 1) begin : g_head
            assign stage_next[gi] = issue ? '{valid: 1'b1, we: id_we, is_load: id_is_load, rd: id_rd}
                                          : '0;
         end else begin : g_tail
            assign stage_next[gi] = stage_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 1; k <= DEPTH; k++) stage_reg[k] <= '0;
      end else if (!hold) begin
         for (int k = 1; k <= DEPTH; k++) stage_reg[k] <= stage_next[k];
      end
   end

   logic [SEL_W-1:0] hit1_sel, hit2_sel;
   logic             lu1, lu2;

   // Scan oldest to youngest so the youngest matching producer is left standing.
   always_comb begin
      hit1_sel = '0;
      hit2_sel = '0;
      lu1      = 1'b0;
      lu2      = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (stage_reg[k].valid && stage_reg[k].we && stage_reg[k].rd == id_rs1 &&
             id_rs1 != '0 && id_rs1_used) begin
            hit1_sel = SEL_W'(k);
            lu1      = stage_reg[k].is_load && (k < LR_EFF);
         end
         if (stage_reg[k].valid && stage_reg[k].we && stage_reg[k].rd == id_rs2 &&
             id_rs2 != '0 && id_rs2_used) begin
            hit2_sel = SEL_W'(k);
            lu2      = stage_reg[k].is_load && (k < LR_EFF);
         end
      end
   end

   assign flush       = ex_branch_taken & ~reset;
   assign stall       = ~reset & ~ex_branch_taken & id_valid & (lu1 | lu2);
   assign fwd_rs1_sel = (id_valid && !reset) ? hit1_sel : '0;
   assign fwd_rs2_sel = (id_valid && !reset) ? hit2_sel : '0;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_count_reg, flush_count_reg;

   // Saturating counters; reset is asynchronous so it needs no extra gating here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count_reg <= '0;
         flush_count_reg <= '0;
      end else if (!hold) begin
         if (stall && stall_count_reg != 32'hFFFF_FFFF) stall_count_reg <= stall_count_reg + 32'd1;
         if (flush && flush_count_reg != 32'hFFFF_FFFF) flush_count_reg <= flush_count_reg + 32'd1;
      end
   end

   assign stall_count = stall_count_reg;
   assign flush_count = flush_count_reg;
`else
   assign stall_count = 32'h0;
   assign flush_count = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (DEPTH=2, LOAD_READY=2): a sequential vector table
// followed by hand-written hold and mid-stall reset sequences.
module tb_hazard_unit;

`ifdef HAZARD_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        hold;
   logic        id_valid;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_rs1_used, id_rs2_used, id_we, id_is_load, ex_branch_taken;
   logic        stall, flush;
   logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
   logic [31:0] stall_count, flush_count;

   int total  = 0;
   int passed = 0;

   hazard_unit #(.DEPTH(2), .RA_W(5), .LOAD_READY(2)) dut (
      .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
      .stall(stall), .flush(flush), .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       vld;
      logic [4:0] rs1, rs2;
      logic       u1, u2;
      logic [4:0] rd;
      logic       we, ld, br;
      logic       e_stall, e_flush;
      logic [1:0] e_sel1, e_sel2;
   } vec_t;

   vec_t vecs [13];

   function automatic vec_t mk(input logic vld, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                               input logic we, input logic ld, input logic br,
                               input logic es, input logic ef,
                               input logic [1:0] s1, input logic [1:0] s2);
      vec_t v;
      v.vld = vld; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd;
      v.we = we; v.ld = ld; v.br = br; v.e_stall = es; v.e_flush = ef;
      v.e_sel1 = s1; v.e_sel2 = s2;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else passed++;
   endtask

   task automatic drive(input vec_t v);
      id_valid = v.vld; id_rs1 = v.rs1; id_rs1_used = v.u1; id_rs2 = v.rs2; id_rs2_used = v.u2;
      id_rd = v.rd; id_we = v.we; id_is_load = v.ld; ex_branch_taken = v.br;
   endtask

   task automatic chk_outs(input string tag, input logic es, input logic ef,
                           input logic [1:0] s1, input logic [1:0] s2);
      chk({tag, ".stall"}, {31'b0, stall}, {31'b0, es});
      chk({tag, ".flush"}, {31'b0, flush}, {31'b0, ef});
      chk({tag, ".sel1"},  {30'b0, fwd_rs1_sel}, {30'b0, s1});
      chk({tag, ".sel2"},  {30'b0, fwd_rs2_sel}, {30'b0, s2});
   endtask

   initial begin
      //            vld rs1 u1 rs2 u2  rd we ld br   stall flush sel1 sel2
      vecs[0]  = mk(1, 1, 1,  2, 1,  5, 1, 0, 0,  0, 0, 0, 0); // ALU rd=5, no deps
      vecs[1]  = mk(1, 5, 1,  0, 1,  6, 1, 0, 0,  0, 0, 1, 0); // rd5 in s1; rs2=0 never fwd
      vecs[2]  = mk(1, 5, 1,  6, 1,  7, 1, 0, 0,  0, 0, 2, 1); // rd5 in s2, rd6 in s1
      vecs[3]  = mk(1, 7, 0,  6, 1,  7, 1, 0, 0,  0, 0, 0, 2); // rs1 unused
      vecs[4]  = mk(1, 0, 1,  7, 1,  0, 1, 0, 0,  0, 0, 0, 1); // rd7 in both: youngest
      vecs[5]  = mk(1, 7, 1,  0, 1,  0, 1, 0, 0,  0, 0, 2, 0); // s1 rd=0 ignored
      vecs[6]  = mk(1, 0, 1,  0, 1,  3, 1, 1, 0,  0, 0, 0, 0); // rd=0 both stages; issue load rd3
      vecs[7]  = mk(1, 3, 1,  1, 0,  4, 1, 0, 0,  1, 0, 1, 0); // load-use stall
      vecs[8]  = mk(1, 3, 1,  1, 0,  4, 1, 0, 0,  0, 0, 2, 0); // load now in s2
      vecs[9]  = mk(0, 4, 1,  1, 0,  1, 1, 0, 0,  0, 0, 0, 0); // invalid decode
      vecs[10] = mk(1, 4, 1,  9, 1,  9, 1, 1, 0,  0, 0, 2, 0); // s1 bubble; issue load rd9
      vecs[11] = mk(1, 9, 1,  1, 0, 10, 1, 0, 1,  0, 1, 1, 0); // load-use + branch: flush wins
      vecs[12] = mk(1,10, 1,  9, 1, 11, 1, 0, 0,  0, 0, 0, 2); // bubble in s1, load at s2

      reset = 1'b1; hold = 1'b0;
      drive(mk(1, 5, 1, 5, 1, 5, 1, 1, 1, 0, 0, 0, 0));
      @(negedge clk);
      chk_outs("reset", 0, 0, 0, 0);
      chk("reset.stall_count", stall_count, 32'd0);
      chk("reset.flush_count", flush_count, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i]);
         @(negedge clk);
         chk_outs($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_sel1, vecs[i].e_sel2);
         $display("vec%0d: stall=%0b flush=%0b sel1=%0d sel2=%0d", i, stall, flush, fwd_rs1_sel, fwd_rs2_sel);
         @(posedge clk); #1;
      end
      chk("table.stall_count", stall_count, STATS ? 32'd1 : 32'd0);
      chk("table.flush_count", flush_count, STATS ? 32'd1 : 32'd0);

      // Hold during a load-use stall
      drive(mk(1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0));
      @(negedge clk);
      chk_outs("hold.load", 0, 0, 0, 0);
      @(posedge clk); #1;
      drive(mk(1, 3, 1, 1, 0, 12, 1, 0, 0, 0, 0, 0, 0));
      hold = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk_outs($sformatf("hold%0d", c), 1, 0, 1, 0);
         $display("hold cycle %0d: stall=%0b sel1=%0d", c, stall, fwd_rs1_sel);
         @(posedge clk); #1;
      end
      chk("hold.stall_count", stall_count, STATS ? 32'd1 : 32'd0);
      hold = 1'b0;
      @(negedge clk);
      chk_outs("hold.last_stall", 1, 0, 1, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk_outs("hold.resume", 0, 0, 2, 0);
      chk("hold.stall_count2", stall_count, STATS ? 32'd2 : 32'd0);
      @(posedge clk); #1;

      // Asynchronous reset in the middle of a stall
      drive(mk(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      drive(mk(1, 8, 1, 12, 1, 13, 1, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      chk_outs("rst.pre", 1, 0, 1, 2);
      #2 reset = 1'b1;
      #1;
      chk_outs("rst.mid", 0, 0, 0, 0);
      chk("rst.stall_count", stall_count, 32'd0);
      chk("rst.flush_count", flush_count, 32'd0);
      $display("reset mid-stall: stall=%0b sel1=%0d sel2=%0d", stall, fwd_rs1_sel, fwd_rs2_sel);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk_outs("rst.after", 0, 0, 0, 0);
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
